// File: rtl/div4_vector_seq.sv
// rtl/div4_vector_seq.sv - sequential 64/32 unsigned restoring divider with valid/ready handshakes
module div4_vector_seq #(
    parameter int BPC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] y3,
    input  logic [15:0] y2,
    input  logic [15:0] y1,
    input  logic [15:0] y0,
    input  logic [15:0] b1,
    input  logic [15:0] b0,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q1,
    output logic [15:0] q0,
    output logic [15:0] r1,
    output logic [15:0] r0,
    output logic        div_by_zero,
    output logic        overflow
);

    localparam int ITER = 32 / BPC;

    // LOAD is a one-cycle classification stage between the handshake and
    // either the flagged result or the iterative loop.
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        rdy_en_q;
    logic [31:0] d_q, d_d;
    logic [31:0] p_q, p_d;
    logic [31:0] l_q, l_d;
    logic [31:0] quo_q, quo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] q_res_q, q_res_d;
    logic [31:0] r_res_q, r_res_d;
    logic        dbz_q, dbz_d;
    logic        ov_q, ov_d;

    logic [32:0] p_s;
    logic [31:0] l_s;
    logic [31:0] quo_s;

    // BPC chained restoring steps; P stays below D so the 33rd bit only
    // matters inside the compare of each step.
    always_comb begin
        p_s   = {1'b0, p_q};
        l_s   = l_q;
        quo_s = quo_q;
        for (int i = 0; i < BPC; i++) begin
            p_s = {p_s[31:0], l_s[31]};
            l_s = {l_s[30:0], 1'b0};
            if (p_s >= {1'b0, d_q}) begin
                p_s   = p_s - {1'b0, d_q};
                quo_s = {quo_s[30:0], 1'b1};
            end else begin
                quo_s = {quo_s[30:0], 1'b0};
            end
        end
    end

    // Next-state and datapath update for the handshake/compute/hold sequence.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        p_d     = p_q;
        l_d     = l_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_res_d = q_res_q;
        r_res_d = r_res_q;
        dbz_d   = dbz_q;
        ov_d    = ov_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    d_d     = {b1, b0};
                    p_d     = {y3, y2};
                    l_d     = {y1, y0};
                    quo_d   = 32'd0;
                    cnt_d   = 6'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (d_q == 32'd0) begin
                    q_res_d = 32'hFFFF_FFFF;
                    r_res_d = l_q;
                    dbz_d   = 1'b1;
                    ov_d    = 1'b0;
                    state_d = S_DONE;
                end else if (p_q >= d_q) begin
                    q_res_d = 32'hFFFF_FFFF;
                    r_res_d = 32'd0;
                    dbz_d   = 1'b0;
                    ov_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                p_d   = p_s[31:0];
                l_d   = l_s;
                quo_d = quo_s;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(ITER - 1)) begin
                    q_res_d = quo_s;
                    r_res_d = p_s[31:0];
                    dbz_d   = 1'b0;
                    ov_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    dbz_d   = 1'b0;
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything and aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rdy_en_q <= 1'b0;
            d_q      <= 32'd0;
            p_q      <= 32'd0;
            l_q      <= 32'd0;
            quo_q    <= 32'd0;
            cnt_q    <= 6'd0;
            q_res_q  <= 32'd0;
            r_res_q  <= 32'd0;
            dbz_q    <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            d_q      <= d_d;
            p_q      <= p_d;
            l_q      <= l_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            q_res_q  <= q_res_d;
            r_res_q  <= r_res_d;
            dbz_q    <= dbz_d;
            ov_q     <= ov_d;
        end
    end

    // in_ready stays low until the first edge after reset release.
    assign in_ready    = rdy_en_q && (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign q1          = q_res_q[31:16];
    assign q0          = q_res_q[15:0];
    assign r1          = r_res_q[31:16];
    assign r0          = r_res_q[15:0];
    assign div_by_zero = dbz_q;
    assign overflow    = ov_q;

endmodule

// File: tb/tb_div4_vector_seq.sv
// tb/tb_div4_vector_seq.sv - directed and random round-trip bench for div4_vector_seq at BPC 1, 2, 4
module tb_div4_vector_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] y3, y2, y1, y0, b1, b0;

    logic        in_ready_w  [3];
    logic        out_valid_w [3];
    logic [15:0] q1_w [3];
    logic [15:0] q0_w [3];
    logic [15:0] r1_w [3];
    logic [15:0] r0_w [3];
    logic        dbz_w [3];
    logic        ov_w  [3];

    int checks;
    int errors;
    int lat [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        div4_vector_seq #(.BPC(1 << g)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid),
            .in_ready    (in_ready_w[g]),
            .y3          (y3),
            .y2          (y2),
            .y1          (y1),
            .y0          (y0),
            .b1          (b1),
            .b0          (b0),
            .out_valid   (out_valid_w[g]),
            .out_ready   (out_ready),
            .q1          (q1_w[g]),
            .q0          (q0_w[g]),
            .r1          (r1_w[g]),
            .r0          (r0_w[g]),
            .div_by_zero (dbz_w[g]),
            .overflow    (ov_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [63:0] y, input logic [31:0] b);
        int w;
        w = 0;
        while (!(in_ready_w[0] && in_ready_w[1] && in_ready_w[2]) && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (w >= 50) begin
            errors++;
            $display("FAIL issue_ready got in_ready=%b%b%b want 111",
                     in_ready_w[0], in_ready_w[1], in_ready_w[2]);
        end
        {y3, y2, y1, y0} = y;
        {b1, b0} = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        {y3, y2, y1, y0} = ~y;
        {b1, b0} = ~b;
        lat[0] = 0; lat[1] = 0; lat[2] = 0;
        for (int n = 1; n <= 40 && !(lat[0] != 0 && lat[1] != 0 && lat[2] != 0); n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                if (out_valid_w[i] && lat[i] == 0) lat[i] = n;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        {y3, y2, y1, y0, b1, b0} = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready_w[i] !== 1'b0 || out_valid_w[i] !== 1'b0 ||
                {q1_w[i], q0_w[i], r1_w[i], r0_w[i]} !== 64'd0 || dbz_w[i] !== 1'b0 || ov_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst=%0d got rdy=%b ov=%b q=%h%h r=%h%h dbz=%b of=%b want all 0",
                         i, in_ready_w[i], out_valid_w[i], q1_w[i], q0_w[i], r1_w[i], r0_w[i], dbz_w[i], ov_w[i]);
            end
        end
        rst_n = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL ready_before_edge inst=%0d got %b want 0", i, in_ready_w[i]);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready_w[i] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_edge inst=%0d got %b want 1", i, in_ready_w[i]);
            end
        end
    endtask

    task automatic test_basic();
        issue(64'h0000_0001_0000_0000, 32'h0000_0002);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lat[i] !== (32 >> i) + 1 || {q1_w[i], q0_w[i]} !== 32'h8000_0000 ||
                {r1_w[i], r0_w[i]} !== 32'd0 || dbz_w[i] !== 1'b0 || ov_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL basic inst=%0d got lat=%0d q=%h%h r=%h%h dbz=%b of=%b want lat=%0d q=80000000 r=0 flags 0",
                         i, lat[i], q1_w[i], q0_w[i], r1_w[i], r0_w[i], dbz_w[i], ov_w[i], (32 >> i) + 1);
            end
        end
        release_out();
    endtask

    task automatic test_bpc();
        issue(64'hFFFF_FFFE_0000_0006, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lat[i] !== (32 >> i) + 1 || {q1_w[i], q0_w[i]} !== 32'hFFFF_FFFF ||
                {r1_w[i], r0_w[i]} !== 32'd5 || dbz_w[i] !== 1'b0 || ov_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL bpc_max inst=%0d got lat=%0d q=%h%h r=%h%h dbz=%b of=%b want lat=%0d q=ffffffff r=5 flags 0",
                         i, lat[i], q1_w[i], q0_w[i], r1_w[i], r0_w[i], dbz_w[i], ov_w[i], (32 >> i) + 1);
            end
        end
        release_out();
    endtask

    task automatic test_flags();
        issue(64'h0000_0000_0000_0007, 32'd0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lat[i] !== 1 || {q1_w[i], q0_w[i]} !== 32'hFFFF_FFFF ||
                {r1_w[i], r0_w[i]} !== 32'd7 || dbz_w[i] !== 1'b1 || ov_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL div_zero inst=%0d got lat=%0d q=%h%h r=%h%h dbz=%b of=%b want lat=1 q=ffffffff r=7 dbz=1 of=0",
                         i, lat[i], q1_w[i], q0_w[i], r1_w[i], r0_w[i], dbz_w[i], ov_w[i]);
            end
        end
        release_out();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid_w[i] !== 1'b0 || dbz_w[i] !== 1'b0 || in_ready_w[i] !== 1'b1) begin
                errors++;
                $display("FAIL flag_clear inst=%0d got ov=%b dbz=%b rdy=%b want 0 0 1",
                         i, out_valid_w[i], dbz_w[i], in_ready_w[i]);
            end
        end
        issue(64'h0000_0002_0000_0000, 32'd2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lat[i] !== 1 || {q1_w[i], q0_w[i]} !== 32'hFFFF_FFFF ||
                {r1_w[i], r0_w[i]} !== 32'd0 || dbz_w[i] !== 1'b0 || ov_w[i] !== 1'b1) begin
                errors++;
                $display("FAIL overflow inst=%0d got lat=%0d q=%h%h r=%h%h dbz=%b of=%b want lat=1 q=ffffffff r=0 dbz=0 of=1",
                         i, lat[i], q1_w[i], q0_w[i], r1_w[i], r0_w[i], dbz_w[i], ov_w[i]);
            end
        end
        release_out();
    endtask

    task automatic test_backpressure();
        issue(64'd100, 32'd7);
        {y3, y2, y1, y0} = 64'd1000;
        {b1, b0} = 32'd3;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_valid_w[i] !== 1'b1 || in_ready_w[i] !== 1'b0 ||
                    {q1_w[i], q0_w[i]} !== 32'd14 || {r1_w[i], r0_w[i]} !== 32'd2) begin
                    errors++;
                    $display("FAIL hold inst=%0d got ov=%b rdy=%b q=%h%h r=%h%h want 1 0 q=0000000e r=00000002",
                             i, out_valid_w[i], in_ready_w[i], q1_w[i], q0_w[i], r1_w[i], r0_w[i]);
                end
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid_w[i] !== 1'b0 || in_ready_w[i] !== 1'b1 || {q1_w[i], q0_w[i]} !== 32'd14) begin
                errors++;
                $display("FAIL handoff inst=%0d got ov=%b rdy=%b q=%h%h want 0 1 q=0000000e",
                         i, out_valid_w[i], in_ready_w[i], q1_w[i], q0_w[i]);
            end
        end
        issue(64'd1000, 32'd3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lat[i] !== (32 >> i) + 1 || {q1_w[i], q0_w[i]} !== 32'd333 || {r1_w[i], r0_w[i]} !== 32'd1) begin
                errors++;
                $display("FAIL after_bp inst=%0d got lat=%0d q=%h%h r=%h%h want lat=%0d q=0000014d r=00000001",
                         i, lat[i], q1_w[i], q0_w[i], r1_w[i], r0_w[i], (32 >> i) + 1);
            end
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int seen;
        {y3, y2, y1, y0} = 64'h0000_0001_0000_0000;
        {b1, b0} = 32'd2;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid_w[i] !== 1'b0 || {q1_w[i], q0_w[i], r1_w[i], r0_w[i]} !== 64'd0 ||
                dbz_w[i] !== 1'b0 || ov_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset inst=%0d got ov=%b q=%h%h r=%h%h dbz=%b of=%b want all 0",
                         i, out_valid_w[i], q1_w[i], q0_w[i], r1_w[i], r0_w[i], dbz_w[i], ov_w[i]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (out_valid_w[0] || out_valid_w[1] || out_valid_w[2]) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL aborted_result got %0d valid cycles want 0", seen);
        end
        issue(64'h0000_0000_0000_0064, 32'h0000_0007);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lat[i] !== (32 >> i) + 1 || {q1_w[i], q0_w[i]} !== 32'h0000_000E || {r1_w[i], r0_w[i]} !== 32'h0000_0002) begin
                errors++;
                $display("FAIL post_reset inst=%0d got lat=%0d q=%h%h r=%h%h want lat=%0d q=0000000e r=00000002",
                         i, lat[i], q1_w[i], q0_w[i], r1_w[i], r0_w[i], (32 >> i) + 1);
            end
        end
        release_out();
    endtask

    task automatic test_random();
        logic [31:0] a, b, r;
        logic [63:0] y;
        for (int k = 0; k < 1000; k++) begin
            a = $urandom;
            b = $urandom;
            if (b == 32'd0) b = 32'd1;
            r = $urandom % b;
            y = {32'd0, a} * {32'd0, b} + {32'd0, r};
            issue(y, b);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({q1_w[i], q0_w[i]} !== a || {r1_w[i], r0_w[i]} !== r ||
                    dbz_w[i] !== 1'b0 || ov_w[i] !== 1'b0 || out_valid_w[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL random inst=%0d y=%h b=%h got q=%h%h r=%h%h dbz=%b of=%b v=%b want q=%h r=%h",
                             i, y, b, q1_w[i], q0_w[i], r1_w[i], r0_w[i], dbz_w[i], ov_w[i], out_valid_w[i], a, r);
                end
            end
            release_out();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_bpc();
        test_flags();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div4_vector_seq.md
Name: div4_vector_seq

Overview:
- Sequential inverse of the 4-word vector multiplier.
- Takes a 64-bit dividend as four 16-bit words (y3..y0, y3 most significant) and a 32-bit divisor as two words (b1,b0).
- Returns the 32-bit quotient as two words (q1,q0) and the 32-bit remainder (r1,r0), so that {y3,y2,y1,y0} = {q1,q0}*{b1,b0} + {r1,r0}.
- Used by the bench/datapath to recover multiplier operands; valid/ready on both sides.

Parameters:
- BPC, 1, quotient bits resolved per clock; legal values 1, 2, 4; iteration count ITER = 32/BPC.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request carries a valid operand set
- in_ready  output  1  block accepts operands this cycle
- y3,y2,y1,y0  input  16 each  dividend words, y3 = bits 63:48
- b1,b0  input  16 each  divisor words, b1 = bits 31:16
- out_valid  output  1  result words and flags are valid
- out_ready  input  1  consumer takes the result this cycle
- q1,q0  output  16 each  quotient words
- r1,r0  output  16 each  remainder words
- div_by_zero  output  1  divisor was zero
- overflow  output  1  quotient does not fit in 32 bits

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - in_ready=0 while rst_n=0, then 1 from the first clk edge after release.
  - out_valid=0; q1,q0,r1,r0=0; both flags=0.
  - Reset asserted mid-CALC or mid-DONE aborts the operation; no result is ever produced for it.
- State IDLE:
  - in_ready=1.
  - Handshake at edge k (in_valid & in_ready): latch D={b1,b0}, H={y3,y2}, L={y1,y0}.
  - Priority, highest first:
    - D==0 -> DONE at k+1 with q=0xFFFF_FFFF, r=L, div_by_zero=1, overflow=0.
    - H>=D -> DONE at k+1 with q=0xFFFF_FFFF, r=0, overflow=1, div_by_zero=0.
    - Otherwise -> CALC with partial remainder P=H (33-bit), shift register L, quotient Q=0, counter=0.
- State CALC:
  - Per cycle, BPC restoring steps, MSB of L first. Each step:
    - P={P[31:0],L[31]}; L=L<<1.
    - If P>=D then P=P-D and shift 1 into Q, else shift 0 into Q.
  - P stays < D after every step, so 33 bits suffice.
  - After ITER cycles -> DONE, with q=Q and r=P[31:0].
  - Latency for a normal result: out_valid rises at edge k+1+ITER (k+33 when BPC=1).
  - in_ready=0 throughout CALC.
- State DONE:
  - out_valid=1, in_ready=0.
  - Outputs and flags are held stable until out_ready=1.
  - On edge with out_valid & out_ready: out_valid=0, flags cleared, go IDLE.
  - No same-cycle accept: the next handshake is possible no earlier than the following edge.
  - q/r retain their last values after the handoff.
- Arithmetic rules:
  - All values unsigned.
  - When the result is not flagged, the invariant {q,r}: dividend = q*D + r with r < D holds exactly.
- Robustness:
  - in_valid toggling outside IDLE is ignored.
  - Operand changes after the handshake do not affect the result.

Test Plan:
- Dividend 0x0000_0001_0000_0000, divisor 0x0000_0002, BPC=1 -> out_valid at k+33, q1=0x8000, q0=0x0000, r=0, flags 0.
- Dividend 0xFFFF_FFFE_0000_0006, divisor 0xFFFF_FFFF -> q=0xFFFF_FFFF, r=0x0000_0005. Repeat with BPC=2 and 4: out_valid at k+17 and k+9, same values.
- Divisor 0, dividend 0x0000_0000_0000_0007 -> out_valid at k+1, div_by_zero=1, q=0xFFFF_FFFF, r=0x0000_0007. Divisor 2, dividend 0x0000_0002_0000_0000 -> overflow=1 at k+1, q=0xFFFF_FFFF, r=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> outputs unchanged, in_ready=0. Release out_ready -> IDLE, then the new operands are accepted on the next edge.
- Assert rst_n=0 at CALC cycle 10 -> out_valid, flags and q/r immediately 0. After release, a new division (0x0000_0000_0000_0064 / 0x0000_0007) yields q=0x0000_000E, r=0x0000_0002.
- Random round-trip: 1000 random a,b with b!=0; dividend=a*b+r with r<b -> q==a and remainder==r, no flags.
